adj_val_gen: RTL and testbench
==============================

Name: adj_val_gen

Overview:
- Upstream stage of the zero counter (zCntr); produces the 7-bit adj_val stream that zCntr consumes.
- Calibrates a baseline by averaging the first 2^CAL_LOG2 valid raw samples.
- Then outputs the deadbanded, saturated magnitude of each raw sample's deviation from that baseline.
- In-band samples therefore arrive at zCntr as exact zeros.

Parameters:
CAL_LOG2, 3, log2 of calibration sample count (8 samples by default); legal range 1..6
DEADBAND, 2, deviation magnitudes <= DEADBAND are output as 0; legal range 0..126

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
raw_in  in  8  unsigned raw sample
raw_vld  in  1  raw_in is valid this cycle
recal  in  1  single-cycle request to discard the baseline and recalibrate
adj_val  out  7  deadbanded, saturated |raw_in - baseline|, registered
adj_vld  out  1  one-cycle pulse: adj_val updated this cycle
cal_done  out  1  high while in RUN (baseline valid)
baseline  out  8  current baseline, registered

Behaviour:
- Reset (async, rst=1):
  - state=CAL; accumulator and sample count cleared.
  - adj_val=0, adj_vld=0, cal_done=0, baseline=0.
- Reset mid-operation: any partial calibration is lost; a full 2^CAL_LOG2 new samples are required.
- States: CAL, RUN. There is no idle state.
- CAL:
  - On raw_vld, add raw_in to an accumulator of width 8+CAL_LOG2 and increment the sample count.
  - Cycles with raw_vld=0 are ignored; gaps are allowed.
  - On the 2^CAL_LOG2-th valid sample, at the next edge:
    - baseline <= (acc + raw_in) >> CAL_LOG2 (truncating).
    - state <= RUN; cal_done <= 1.
  - That last calibration sample produces no adj output.
  - In CAL, adj_val is held at 0 and adj_vld=0.
- RUN:
  - On raw_vld, compute diff = raw_in - baseline as a 9-bit signed value; mag = |diff| (0..255).
  - If mag <= DEADBAND, out=0. Else if mag > 127, out=127 (saturate). Else out=mag.
  - Next edge: adj_val <= out, adj_vld <= 1. Latency is 1 cycle from the raw_vld sample.
  - raw_vld=0: adj_val holds its previous value; adj_vld=0.
  - Back-to-back raw_vld gives one output per cycle; there is no backpressure.
- recal (any state): at the next edge:
  - state <= CAL; accumulator and count cleared.
  - cal_done <= 0; adj_val <= 0; adj_vld <= 0.
  - baseline holds its old value until the new calibration completes.
- recal together with raw_vld in the same cycle: recal wins; the sample is discarded and not accumulated.
- recal on the final calibration sample: recal wins; calibration restarts and baseline is not updated.
- Wrap-around: the count is exactly CAL_LOG2+1 bits and is cleared on CAL->RUN. The accumulator cannot overflow (255 * 2^CAL_LOG2 fits in 8+CAL_LOG2 bits).
- Boundaries:
  - raw_in=0 with baseline=255 gives mag 255, output 127.
  - mag=DEADBAND gives 0; mag=DEADBAND+1 passes through.

Test Plan:
- Reset -> adj_val=0, adj_vld=0, cal_done=0, baseline=0; raw_vld pulses during reset are ignored.
- 8 valid samples of 100 with 2 idle cycles interleaved -> cal_done=1 and baseline=100 one cycle after the 8th sample; no adj_vld pulse during CAL.
- RUN, baseline=100, raw 150,101,95,102,103 back-to-back -> adj_val 50,0,5,0,3 each one cycle later; adj_vld high for 5 consecutive cycles.
- Baseline=100, raw 255 then raw 0 -> adj_val 127 (saturated), then 100; a raw_vld=0 cycle afterward keeps adj_val=100 with adj_vld=0.
- In RUN, recal asserted with raw_vld and raw_in=200 -> next cycle cal_done=0, adj_val=0, baseline still 100. Then 8 samples of 40 give baseline=40, and raw 40 outputs 0.
- Mid-CAL after 5 samples of 60, pulse rst -> all outputs at reset values. Then 8 samples of 20 -> baseline=20, not a blend with 60.

Source files
------------

// File: rtl/adj_val_gen_if.sv
// Sample/adjusted-value bus between the raw sample source, adj_val_gen and its zCntr consumer.
// The master drives raw samples and recal; the slave (adj_val_gen) returns the adjusted stream.
interface adj_val_gen_if;
  logic [7:0] raw_in;
  logic       raw_vld;
  logic       recal;
  logic [6:0] adj_val;
  logic       adj_vld;
  logic       cal_done;
  logic [7:0] baseline;

  modport master (
    output raw_in, raw_vld, recal,
    input  adj_val, adj_vld, cal_done, baseline
  );

  modport slave (
    input  raw_in, raw_vld, recal,
    output adj_val, adj_vld, cal_done, baseline
  );
endinterface

// File: rtl/adj_val_gen.sv
// Baseline calibration (mean of the first 2^CAL_LOG2 valid samples) followed by
// deadbanded, saturated |raw - baseline| output feeding the zero counter.
module adj_val_gen #(
  parameter int CAL_LOG2 = 3,
  parameter int DEADBAND = 2
) (
  input  logic          clk,
  input  logic          rst,
  adj_val_gen_if.slave  bus
);

  localparam int ACC_W   = 8 + CAL_LOG2;
  localparam int CNT_W   = CAL_LOG2 + 1;
  localparam int NUM_CAL = 2 ** CAL_LOG2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAL - 1);
  localparam logic [8:0]       DB_MAG   = 9'(DEADBAND);

  typedef enum logic {CAL, RUN} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_avg;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [6:0]        out_val;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    acc_sum = acc + ACC_W'(bus.raw_in);
    acc_avg = acc_sum >> CAL_LOG2;
    diff    = $signed({1'b0, bus.raw_in}) - $signed({1'b0, bus.baseline});
    mag     = diff[8] ? 9'(-diff) : 9'(diff);
    out_val = 7'd0;
    if (mag > DB_MAG) begin
      out_val = (mag > 9'd127) ? 7'd127 : mag[6:0];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CAL;
      acc          <= '0;
      cnt          <= '0;
      bus.adj_val  <= '0;
      bus.adj_vld  <= 1'b0;
      bus.cal_done <= 1'b0;
      bus.baseline <= '0;
    end else if (bus.recal) begin
      // Baseline is deliberately kept until a fresh calibration replaces it.
      state        <= CAL;
      acc          <= '0;
      cnt          <= '0;
      bus.adj_val  <= '0;
      bus.adj_vld  <= 1'b0;
      bus.cal_done <= 1'b0;
    end else begin
      case (state)
        CAL: begin
          bus.adj_val <= '0;
          bus.adj_vld <= 1'b0;
          if (bus.raw_vld) begin
            if (cnt == LAST_CNT) begin
              bus.baseline <= acc_avg[7:0];
              bus.cal_done <= 1'b1;
              state        <= RUN;
              acc          <= '0;
              cnt          <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          bus.adj_vld <= bus.raw_vld;
          if (bus.raw_vld) begin
            bus.adj_val <= out_val;
          end
        end
        default: state <= CAL;
      endcase
    end
  end

endmodule

// File: tb/tb_adj_val_gen.sv
// Self-checking bench for adj_val_gen: directed plan steps plus a random phase,
// all checked against an arithmetic reference model of calibration and deadbanding.
module tb_adj_val_gen;

  localparam int CAL_LOG2 = 3;
  localparam int DEADBAND = 2;
  localparam int NUM_CAL  = 2 ** CAL_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  adj_val_gen_if bus ();

  adj_val_gen #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  bit m_cal;
  int m_sum, m_cnt, m_base, m_adj_val, m_adj_vld, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expected_out(input int raw, input int base);
    int d;
    d = raw - base;
    if (d < 0) d = -d;
    if (d <= DEADBAND) return 0;
    if (d > 127) return 127;
    return d;
  endfunction

  task automatic model_reset();
    m_cal = 1; m_sum = 0; m_cnt = 0; m_base = 0;
    m_adj_val = 0; m_adj_vld = 0; m_done = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".adj_val"},  32'(bus.adj_val),  32'(m_adj_val));
    check({tag, ".adj_vld"},  32'(bus.adj_vld),  32'(m_adj_vld));
    check({tag, ".cal_done"}, 32'(bus.cal_done), 32'(m_done));
    check({tag, ".baseline"}, 32'(bus.baseline), 32'(m_base));
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input int raw, input bit vld, input bit rc, input string tag);
    bus.raw_in  = 8'(raw);
    bus.raw_vld = vld;
    bus.recal   = rc;
    @(posedge clk);
    if (rc) begin
      m_cal = 1; m_sum = 0; m_cnt = 0; m_done = 0; m_adj_val = 0; m_adj_vld = 0;
    end else if (m_cal) begin
      m_adj_val = 0; m_adj_vld = 0;
      if (vld) begin
        m_sum += raw;
        m_cnt++;
        if (m_cnt == NUM_CAL) begin
          m_base = m_sum / NUM_CAL;
          m_cal = 0; m_done = 1; m_sum = 0; m_cnt = 0;
        end
      end
    end else begin
      m_adj_vld = vld;
      if (vld) m_adj_val = expected_out(raw, m_base);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic calibrate(input int val, input string tag);
    for (int i = 0; i < NUM_CAL; i++) step(val, 1'b1, 1'b0, tag);
  endtask

  initial begin
    bus.raw_in = '0; bus.raw_vld = 1'b0; bus.recal = 1'b0;
    model_reset();

    // Reset, with raw_vld pulses that must be ignored
    rst = 1'b1;
    #1;
    check_outputs("reset");
    for (int i = 0; i < 3; i++) begin
      bus.raw_in = 8'd77; bus.raw_vld = 1'b1;
      @(posedge clk); #1;
      check_outputs("reset_vld");
    end
    bus.raw_vld = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Calibration of 100s with idle gaps
    for (int i = 0; i < NUM_CAL; i++) begin
      step(100, 1'b1, 1'b0, "cal100");
      if (i == 2 || i == 5) step(0, 1'b0, 1'b0, "cal100_gap");
    end
    check("plan.base100", 32'(bus.baseline), 32'd100);
    check("plan.done", 32'(bus.cal_done), 32'd1);

    // Back-to-back RUN samples
    step(150, 1'b1, 1'b0, "run150");
    check("plan.adj50", 32'(bus.adj_val), 32'd50);
    step(101, 1'b1, 1'b0, "run101");
    step(95,  1'b1, 1'b0, "run95");
    check("plan.adj5", 32'(bus.adj_val), 32'd5);
    step(102, 1'b1, 1'b0, "run102_db");
    step(103, 1'b1, 1'b0, "run103_db1");
    check("plan.adj3", 32'(bus.adj_val), 32'd3);

    // Saturation and hold
    step(255, 1'b1, 1'b0, "sat255");
    check("plan.sat", 32'(bus.adj_val), 32'd127);
    step(0, 1'b1, 1'b0, "raw0");
    step(0, 1'b0, 1'b0, "hold");
    check("plan.hold", 32'(bus.adj_val), 32'd100);

    // recal with a simultaneous sample, then recalibrate to 40
    step(200, 1'b1, 1'b1, "recal_vld");
    check("plan.recal_base", 32'(bus.baseline), 32'd100);
    calibrate(40, "cal40");
    check("plan.base40", 32'(bus.baseline), 32'd40);
    step(40, 1'b1, 1'b0, "run40");
    step(42, 1'b1, 1'b0, "db_hi");
    step(43, 1'b1, 1'b0, "db_hi1");
    step(38, 1'b1, 1'b0, "db_lo");
    step(37, 1'b1, 1'b0, "db_lo1");

    // recal on the final calibration sample
    step(0, 1'b0, 1'b1, "recal_run");
    for (int i = 0; i < NUM_CAL - 1; i++) step(90, 1'b1, 1'b0, "cal90");
    step(90, 1'b1, 1'b1, "recal_last");
    check("plan.recal_last_base", 32'(bus.baseline), 32'd40);

    // Baseline 255, raw 0 saturates
    calibrate(255, "cal255");
    step(0, 1'b1, 1'b0, "sat_min");

    // Mid-calibration asynchronous reset
    step(0, 1'b0, 1'b1, "recal_pre");
    for (int i = 0; i < 5; i++) step(60, 1'b1, 1'b0, "cal60");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk) rst = 1'b0;
    calibrate(20, "cal20");
    check("plan.base20", 32'(bus.baseline), 32'd20);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      int raw;
      bit vld, rc;
      vld = ($urandom_range(3) != 0);
      rc  = ($urandom_range(39) == 0);
      if ($urandom_range(1) == 0)
        raw = m_base + int'($urandom_range(8)) - 4;
      else
        raw = int'($urandom_range(255));
      if (raw < 0) raw = 0;
      if (raw > 255) raw = 255;
      step(raw, vld, rc, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
